// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared constants and helpers for the arbitrating multiplexer
package arb_mux_pkg;

   localparam int ARB_MUX_MAX_CH = 16;

   // Channel-index width; a single channel still needs one bit to carry out_ch.
   function automatic int selw_f(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority arbiter, search starts at ptr
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter int CH   = 4,
   parameter int SELW = selw_f(CH)
)(
   input  logic [CH-1:0]   req,
   input  logic [SELW-1:0] ptr,
   output logic [CH-1:0]   grant,
   output logic [SELW-1:0] grant_idx
);

   logic            found;
   logic [SELW:0]   sum;
   logic [SELW-1:0] idx;

   // Wrap by subtraction so non-power-of-2 channel counts rotate correctly.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < CH; k++) begin
         sum = {1'b0, ptr} + (SELW+1)'(k);
         if (sum >= (SELW+1)'(CH)) begin
            sum = sum - (SELW+1)'(CH);
         end
         idx = sum[SELW-1:0];
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel round-robin arbitrating mux with one registered output stage
// Define ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CH    = 4,
   parameter int SELW  = selw_f(CH)
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CH-1:0]       in_valid,
   output logic [CH-1:0]       in_ready,
   input  logic [CH*WIDTH-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [SELW-1:0]     out_ch
);

   generate
      if (CH < 1 || CH > ARB_MUX_MAX_CH) begin : g_ch_range
         $error("arb_mux: CH must be within 1..16");
      end
   endgenerate

   logic [CH-1:0]    grant;
   logic [SELW-1:0]  grant_idx;
   logic [SELW-1:0]  arb_ptr;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] ch_data [CH];

   for (genvar i = 0; i < CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   assign load     = !out_valid || out_ready;
   // Gated by reset_n so nothing is accepted while the block is held in reset.
   assign in_ready = (reset_n && load) ? grant : '0;
   assign xfer     = |(in_valid & in_ready);

`ifdef ARB_MUX_FIXED_PRIO_EN
   assign arb_ptr = '0;
`else
   logic [SELW-1:0] rr_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
      end else if (xfer) begin
         rr_ptr <= (grant_idx == SELW'(CH-1)) ? '0 : grant_idx + SELW'(1);
      end
   end

   assign arb_ptr = rr_ptr;
`endif

   rr_arbiter #(
      .CH   (CH),
      .SELW (SELW)
   ) u_rr_arbiter (
      .req       (in_valid),
      .ptr       (arb_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Drain without fill keeps stale out_data/out_ch; only out_valid drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= ch_data[grant_idx];
         out_ch    <= grant_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - scoreboard bench for arb_mux with a queue-based reference model
module tb_arb_mux;

   localparam int WIDTH = 32;
   localparam int CH    = 4;
   localparam int SELW  = 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [CH-1:0]       in_valid;
   logic [CH-1:0]       in_ready;
   logic [CH*WIDTH-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_data;
   logic [SELW-1:0]     out_ch;

   logic [WIDTH-1:0]    d [CH];

   always #5 clk = ~clk;

   for (genvar g = 0; g < CH; g++) begin : g_pack
      assign in_data[g*WIDTH +: WIDTH] = d[g];
   end

   arb_mux #(.WIDTH(WIDTH), .CH(CH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch)
   );

   typedef struct {
      int               ch;
      logic [WIDTH-1:0] data;
   } beat_t;

   beat_t            sbq [$];
   beat_t            b;
   int               n_checks = 0;
   int               n_pass   = 0;
   int               m_ptr    = 0;
   bit               m_occ    = 1'b0;
   int               exp_ch;
   logic [CH-1:0]    exp_rdy;
   logic [CH-1:0]    acc      = '0;
   logic [WIDTH-1:0] last_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: one-deep output slot, a rotating start index, first requester wins.
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_in_ready", in_ready, '0);
         chk("rst_out_valid", out_valid, 0);
         sbq.delete();
         m_occ = 1'b0;
         m_ptr = 0;
         acc   = '0;
      end else begin
         chk("out_valid", out_valid, m_occ);
         if (out_valid && out_ready) begin
            chk("beat_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               b = sbq.pop_front();
               chk("out_ch", out_ch, b.ch);
               chk("out_data", out_data, b.data);
            end
         end
         exp_ch = -1;
         if (!m_occ || out_ready) begin
            for (int k = 0; k < CH; k++) begin
               if (exp_ch < 0 && in_valid[(m_ptr + k) % CH]) exp_ch = (m_ptr + k) % CH;
            end
         end
         exp_rdy = (exp_ch >= 0) ? (CH'(1) << exp_ch) : '0;
         chk("in_ready", in_ready, exp_rdy);
         acc = exp_rdy;
         if (exp_ch >= 0) begin
            sbq.push_back('{exp_ch, d[exp_ch]});
            last_data = d[exp_ch];
            m_occ     = 1'b1;
`ifndef ARB_MUX_FIXED_PRIO_EN
            m_ptr     = (exp_ch + 1) % CH;
`endif
         end else if (out_ready) begin
            m_occ = 1'b0;
         end
      end
   end

   // Requesters hold valid/data until accepted; a wanted channel re-requests right after acceptance.
   task automatic step(input logic [CH-1:0] want, input logic rdy, input bit fixed);
      @(posedge clk);
      #1;
      for (int i = 0; i < CH; i++) begin
         if (acc[i]) in_valid[i] = 1'b0;
         if (!in_valid[i] && want[i]) begin
            in_valid[i] = 1'b1;
            d[i]        = fixed ? (32'hA0 + WIDTH'(i)) : $urandom;
         end
      end
      out_ready = rdy;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = '1;
      out_ready = 1'b0;
      for (int i = 0; i < CH; i++) d[i] = 32'hA0 + WIDTH'(i);
      repeat (3) @(negedge clk);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_data", out_data, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      repeat (6) step('1, 1'b0, 1'b1);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 32'hA0);
      chk("bp_out_ch", out_ch, 0);

      repeat (8) step('1, 1'b1, 1'b1);
      repeat (8) step('0, 1'b1, 1'b1);
      @(negedge clk);
      chk("drain_out_valid", out_valid, 0);
      chk("drain_stale_data", out_data, last_data);

      step(4'b0100, 1'b1, 1'b1);
      repeat (2) step('0, 1'b1, 1'b1);
      step(4'b0010, 1'b1, 1'b1);
      repeat (2) step('0, 1'b1, 1'b1);
      step(4'b0001, 1'b1, 1'b1);
      repeat (2) step('0, 1'b1, 1'b1);

      for (int k = 0; k < 400; k++) begin
         step(CH'($urandom), $urandom_range(0, 3) != 0, 1'b0);
         if (k == 200) reset_n = 1'b0;
         if (k == 203) reset_n = 1'b1;
      end

      repeat (10) step('0, 1'b1, 1'b0);
      @(negedge clk);
      chk("sb_empty", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- N-channel, parametrised-width round-robin arbitrating multiplexer with valid/ready handshakes and a single registered output stage.
- Successor to the fixed 4/8-way combinational selectors: the select is generated internally by arbitration, not supplied by the caller.
- Sits between multiple requesters (e.g. CP0/bridge/peripheral response paths) and one shared consumer.

Parameters:
- WIDTH, 32, data width per channel in bits.
- CH, 4, number of input channels, 1..16.
- SELW, (CH>1 ? $clog2(CH) : 1), channel-index width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  CH  per-channel request valid.
- in_ready  output  CH  per-channel accept; one-hot or zero.
- in_data  input  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  registered index of the channel that supplied out_data.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset, asynchronous on reset_n low: out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is combinational and therefore 0 while out_valid=0 with no requests.
- load = !out_valid || out_ready. The output register can take a beat this cycle.
- Arbitration is combinational.
  - Search channels rr_ptr, rr_ptr+1, …, CH-1, 0, …, rr_ptr-1 and grant the first with in_valid=1.
  - grant is one-hot, or zero if no request.
- in_ready[i] = load && grant[i]. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer: out_data<=in_data[i], out_ch<=i, out_valid<=1, rr_ptr<=(i==CH-1)?0:i+1. This wrap rule also holds for non-power-of-2 CH.
- If out_valid && out_ready and there is no transfer: out_valid<=0. out_data and out_ch hold their stale values.
- If out_valid && !out_ready: the register holds, all in_ready=0, and rr_ptr holds.
- Simultaneous drain and fill: the same-cycle handoff gives full throughput of 1 beat/cycle with no bubble.
- Latency: input transfer to out_valid is 1 cycle.
- Fairness: a continuously requesting channel is served within CH transfers.
- Requesters must hold in_valid and in_data until accepted. The block does not check this.
- CH=1: grant = in_valid[0]; rr_ptr stays 0.
- Reset mid-beat: any held beat is discarded and no in_ready is asserted until reset_n deasserts.
- Grant depends only on registered state and in_valid, never on in_data. There is no combinational path from out_ready to out_data.

Optional Feature:
- Macro ARB_MUX_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, lowest index highest. The rr_ptr register is removed and the search always starts at 0. All handshake rules are unchanged.
- Undefined (default): round-robin as specified above.

Decomposition:
- Shared package arb_mux_pkg holds:
  - a function computing SELW from CH;
  - a constant ARB_MUX_MAX_CH=16, checked by an elaboration-time assertion.
- One natural sub-module, rr_arbiter:
  - inputs: req[CH], ptr[SELW];
  - outputs: grant[CH], grant_idx[SELW].
- rr_arbiter is pure combinational, so it can be reused by the future bus bridge.
- The register stage and pointer stay in arb_mux.

Test Plan:
- Reset: hold reset_n=0 with in_valid=4'b1111 → out_valid=0, in_ready=0, out_ch=0. Release reset_n → the first grant is ch0 (rr_ptr=0).
- Round-robin: CH=4, all in_valid=1, in_data[i]=32'hA0+i, out_ready=1 → out_ch sequence 0,1,2,3,0 on consecutive cycles, with one beat per cycle.
- Backpressure: out_ready=0 after the first beat (ch0) → out_valid stays 1, out_data=32'hA0 holds, in_ready=0 for 5 cycles. Raise out_ready → the next beat is ch1.
- Sparse/wrap: rr_ptr=3, only in_valid[1]=1 → ch1 granted, then rr_ptr=2. Next, only in_valid[0]=1 → ch0 granted (wrap past 3).
- Drain-without-fill: a single beat followed by in_valid=0, out_ready=1 → out_valid drops the cycle after acceptance, out_data holds its stale value.
- ARB_MUX_FIXED_PRIO_EN defined, all in_valid=1, out_ready=1 → out_ch=0 every cycle. Drop in_valid[0] → out_ch=1 every cycle.
